// File: rtl/mips_cpu_if.sv
// mips_cpu_if: bus bundle between the mips_cpu core, its instruction ROM,
// its data RAM and the writeback/memory trace observer.
interface mips_cpu_if;
  logic [31:0] macroscopic_pc;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_rdata;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata;
  logic [31:0] w_inst_addr;

  // Core side: drives fetch/data addresses and the trace outputs.
  modport master (
    output macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen,
           m_inst_addr, w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
    input  i_inst_rdata, m_data_rdata
  );

  // Memory/observer side.
  modport slave (
    input  macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen,
           m_inst_addr, w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
    output i_inst_rdata, m_data_rdata
  );
endinterface

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS-subset core with CP0 exception handling.
// One instruction retires per clock, no branch delay slots.
// Optional feature: define INTERRUPT_EN to honour the external interrupt input.
module mips_cpu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] DM_TOP     = 32'h0000_2FFF,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       interrupt,
  mips_cpu_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2a;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Architectural state
  logic [31:0] r_pc;
  logic [31:0] r_grf [32];
  logic [5:0]  r_srIm;
  logic        r_srExl;
  logic        r_srIe;
  logic [4:0]  r_excCode;
  logic [31:0] r_epc;

  // Instruction fields and datapath wires
  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_jumpPc;
  logic [31:0] w_branchTaken;
  logic [31:0] w_rsVal;
  logic [31:0] w_rtVal;
  logic [31:0] w_dataAddr;
  logic [31:0] w_addRR;
  logic [31:0] w_subRR;
  logic        w_ovAdd;
  logic        w_ovSub;
  logic        w_ovAddi;
  logic        w_dataOut;
  logic [7:0]  w_loadByte;
  logic [31:0] w_srVal;
  logic [31:0] w_causeVal;
  logic [5:0]  w_causeIp;
  logic [31:0] w_cp0Rd;
  logic        w_intReq;
  logic        w_fetchAdel;
  logic        w_dataAdel;
  logic        w_dataAdes;

  // Decoder outputs
  logic        w_regWrite;
  logic [4:0]  w_dest;
  logic [31:0] w_result;
  logic [31:0] w_seqPc;
  logic        w_ri;
  logic        w_sys;
  logic        w_ov;
  logic        w_isLw;
  logic        w_isLb;
  logic        w_isSw;
  logic        w_isSb;
  logic        w_isMtc0;
  logic        w_isEret;

  // Exception / commit control
  logic        w_excTaken;
  logic [4:0]  w_excCode;
  logic [31:0] w_nextPc;
  logic        w_grfWe;

  assign w_instr   = bus.i_inst_rdata;
  assign w_op      = w_instr[31:26];
  assign w_rs      = w_instr[25:21];
  assign w_rt      = w_instr[20:16];
  assign w_rd      = w_instr[15:11];
  assign w_funct   = w_instr[5:0];
  assign w_imm     = w_instr[15:0];
  assign w_simm    = {{16{w_imm[15]}}, w_imm};
  assign w_zimm    = {16'b0, w_imm};
  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_jumpPc  = {w_pcPlus4[31:28], w_instr[25:0], 2'b00};
  assign w_branchTaken = w_pcPlus4 + {w_simm[29:0], 2'b00};

  assign w_rsVal    = (w_rs == 5'd0) ? 32'b0 : r_grf[w_rs];
  assign w_rtVal    = (w_rt == 5'd0) ? 32'b0 : r_grf[w_rt];
  assign w_dataAddr = w_rsVal + w_simm;
  assign w_addRR    = w_rsVal + w_rtVal;
  assign w_subRR    = w_rsVal - w_rtVal;

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result flips sign.
  assign w_ovAdd  = (w_rsVal[31] == w_rtVal[31]) && (w_addRR[31] != w_rsVal[31]);
  assign w_ovSub  = (w_rsVal[31] != w_rtVal[31]) && (w_subRR[31] != w_rsVal[31]);
  assign w_ovAddi = (w_rsVal[31] == w_simm[31])  && (w_dataAddr[31] != w_rsVal[31]);

  assign w_dataOut  = (w_dataAddr > DM_TOP);
  assign w_loadByte = bus.m_data_rdata[{w_dataAddr[1:0], 3'b000} +: 8];

  assign w_fetchAdel = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || (r_pc > IM_TOP);

`ifdef INTERRUPT_EN
  assign w_causeIp = {interrupt, 5'b0};
  assign w_intReq  = interrupt & r_srIm[5] & r_srIe & ~r_srExl;
`else
  logic w_unusedInterrupt;
  assign w_unusedInterrupt = interrupt;
  assign w_causeIp = 6'b0;
  assign w_intReq  = 1'b0;
`endif

  assign w_srVal    = {16'b0, r_srIm, 8'b0, r_srExl, r_srIe};
  assign w_causeVal = {16'b0, w_causeIp, 3'b0, r_excCode, 2'b00};

  // CP0 read mux for mfc0; unimplemented registers read as zero.
  always_comb begin
    w_cp0Rd = 32'b0;
    case (w_rd)
      5'd12:   w_cp0Rd = w_srVal;
      5'd13:   w_cp0Rd = w_causeVal;
      5'd14:   w_cp0Rd = r_epc;
      default: w_cp0Rd = 32'b0;
    endcase
  end

  // Main decoder: GRF result, destination, sequential next PC and raw fault flags.
  always_comb begin
    w_regWrite = 1'b0;
    w_dest     = w_rt;
    w_result   = 32'b0;
    w_seqPc    = w_pcPlus4;
    w_ri       = 1'b0;
    w_sys      = 1'b0;
    w_ov       = 1'b0;
    w_isLw     = 1'b0;
    w_isLb     = 1'b0;
    w_isSw     = 1'b0;
    w_isSb     = 1'b0;
    w_isMtc0   = 1'b0;
    w_isEret   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_dest = w_rd;
        case (w_funct)
          FN_ADD:     begin w_regWrite = 1'b1; w_result = w_addRR; w_ov = w_ovAdd; end
          FN_ADDU:    begin w_regWrite = 1'b1; w_result = w_addRR; end
          FN_SUB:     begin w_regWrite = 1'b1; w_result = w_subRR; w_ov = w_ovSub; end
          FN_SUBU:    begin w_regWrite = 1'b1; w_result = w_subRR; end
          FN_AND:     begin w_regWrite = 1'b1; w_result = w_rsVal & w_rtVal; end
          FN_OR:      begin w_regWrite = 1'b1; w_result = w_rsVal | w_rtVal; end
          FN_SLT:     begin
            w_regWrite = 1'b1;
            w_result   = {31'b0, $signed(w_rsVal) < $signed(w_rtVal)};
          end
          FN_JR:      w_seqPc = w_rsVal;
          FN_SYSCALL: w_sys = 1'b1;
          default:    w_ri = 1'b1;
        endcase
      end
      OP_ADDI: begin w_regWrite = 1'b1; w_result = w_dataAddr; w_ov = w_ovAddi; end
      OP_ORI:  begin w_regWrite = 1'b1; w_result = w_rsVal | w_zimm; end
      OP_LUI:  begin w_regWrite = 1'b1; w_result = {w_imm, 16'b0}; end
      OP_LW:   begin w_regWrite = 1'b1; w_isLw = 1'b1; w_result = bus.m_data_rdata; end
      OP_LB:   begin
        w_regWrite = 1'b1;
        w_isLb     = 1'b1;
        w_result   = {{24{w_loadByte[7]}}, w_loadByte};
      end
      OP_SW:   w_isSw = 1'b1;
      OP_SB:   w_isSb = 1'b1;
      OP_BEQ:  if (w_rsVal == w_rtVal) w_seqPc = w_branchTaken;
      OP_BNE:  if (w_rsVal != w_rtVal) w_seqPc = w_branchTaken;
      OP_J:    w_seqPc = w_jumpPc;
      OP_JAL:  begin
        w_regWrite = 1'b1;
        w_dest     = 5'd31;
        w_result   = w_pcPlus4;
        w_seqPc    = w_jumpPc;
      end
      OP_COP0: begin
        if (w_instr == ERET_WORD) begin
          w_isEret = 1'b1;
        end else if (w_rs == 5'd0) begin
          w_regWrite = 1'b1;
          w_result   = w_cp0Rd;
        end else if (w_rs == 5'd4) begin
          w_isMtc0 = 1'b1;
        end else begin
          w_ri = 1'b1;
        end
      end
      default: w_ri = 1'b1;
    endcase
  end

  assign w_dataAdel = (w_isLw && ((w_dataAddr[1:0] != 2'b00) || w_dataOut)) || (w_isLb && w_dataOut);
  assign w_dataAdes = (w_isSw && ((w_dataAddr[1:0] != 2'b00) || w_dataOut)) || (w_isSb && w_dataOut);

  // Exception arbitration, highest priority first.
  always_comb begin
    w_excTaken = 1'b1;
    w_excCode  = EXC_INT;
    if (w_intReq)         w_excCode = EXC_INT;
    else if (w_fetchAdel) w_excCode = EXC_ADEL;
    else if (w_ri)        w_excCode = EXC_RI;
    else if (w_sys)       w_excCode = EXC_SYS;
    else if (w_ov)        w_excCode = EXC_OV;
    else if (w_dataAdel)  w_excCode = EXC_ADEL;
    else if (w_dataAdes)  w_excCode = EXC_ADES;
    else                  w_excTaken = 1'b0;
  end

  // Next PC: exceptions vector to the handler, eret returns to EPC.
  always_comb begin
    w_nextPc = w_seqPc;
    if (w_excTaken)    w_nextPc = HANDLER_PC;
    else if (w_isEret) w_nextPc = r_epc;
  end

  assign w_grfWe = !reset && !w_excTaken && w_regWrite && (w_dest != 5'd0);

  assign bus.macroscopic_pc = r_pc;
  assign bus.i_inst_addr    = r_pc;
  assign bus.m_inst_addr    = r_pc;
  assign bus.w_inst_addr    = r_pc;
  assign bus.m_data_addr    = w_dataAddr;
  assign bus.m_data_wdata   = w_isSb ? {4{w_rtVal[7:0]}} : w_rtVal;
  assign bus.m_data_byteen  = (reset || w_excTaken) ? 4'b0000 :
                              w_isSw ? 4'b1111 :
                              w_isSb ? (4'b0001 << w_dataAddr[1:0]) : 4'b0000;
  assign bus.w_grf_we       = w_grfWe;
  assign bus.w_grf_addr     = w_dest;
  assign bus.w_grf_wdata    = w_result;

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_nextPc;
  end

  // General register file write port; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_grf[i] <= 32'b0;
    end else if (w_grfWe) begin
      r_grf[w_dest] <= w_result;
    end
  end

  // CP0 state: exception entry, mtc0 writes to SR/EPC, eret leaves exception level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_srIm    <= 6'b0;
      r_srExl   <= 1'b0;
      r_srIe    <= 1'b0;
      r_excCode <= 5'b0;
      r_epc     <= 32'b0;
    end else if (w_excTaken) begin
      r_excCode <= w_excCode;
      if (!r_srExl) r_epc <= r_pc;
      r_srExl <= 1'b1;
    end else begin
      if (w_isMtc0 && (w_rd == 5'd12)) begin
        r_srIm  <= w_rtVal[15:10];
        r_srExl <= w_rtVal[1];
        r_srIe  <= w_rtVal[0];
      end
      if (w_isMtc0 && (w_rd == 5'd14)) r_epc <= w_rtVal;
      if (w_isEret) r_srExl <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed, table-driven bench for mips_cpu. The bench supplies
// the instruction word of each cycle directly and models the data RAM.
module tb_mips_cpu;

  logic clk;
  logic reset;
  logic interrupt;
  mips_cpu_if bus();

  mips_cpu dut (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .bus       (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        irq;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] ma;
    logic [31:0] md;
  } vec_t;

  vec_t vecs [0:63];
  int   nVec   = 0;
  int   nCheck = 0;
  int   nPass  = 0;
  int   nFail  = 0;

  logic [31:0] dmem [0:3071];

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data RAM read: combinational word read, zero outside the RAM.
  always_comb begin
    bus.m_data_rdata = 32'b0;
    if (bus.m_data_addr <= 32'h0000_2FFF) bus.m_data_rdata = dmem[bus.m_data_addr[13:2]];
  end

  // Data RAM write: byte lanes on posedge; cleared while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3072; i++) dmem[i] <= 32'b0;
    end else if (bus.m_data_addr <= 32'h0000_2FFF) begin
      for (int b = 0; b < 4; b++)
        if (bus.m_data_byteen[b]) dmem[bus.m_data_addr[13:2]][8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
    end
  end

  task automatic addVec(input logic [31:0] pc, input logic [31:0] instr, input logic irq,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] ma, input logic [31:0] md);
    vecs[nVec] = '{pc, instr, irq, we, wa, wd, be, ma, md};
    nVec++;
  endtask

  task automatic addW(input logic [31:0] pc, input logic [31:0] instr, input logic irq,
                      input logic [4:0] wa, input logic [31:0] wd);
    addVec(pc, instr, irq, 1'b1, wa, wd, 4'b0000, 32'b0, 32'b0);
  endtask

  task automatic addN(input logic [31:0] pc, input logic [31:0] instr, input logic irq);
    addVec(pc, instr, irq, 1'b0, 5'd0, 32'b0, 4'b0000, 32'b0, 32'b0);
  endtask

  task automatic addM(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [3:0] be, input logic [31:0] ma, input logic [31:0] md);
    addVec(pc, instr, 1'b0, 1'b0, 5'd0, 32'b0, be, ma, md);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic irq);
    bus.i_inst_rdata = instr;
    interrupt        = irq;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCheck++;
    if (act === exp) begin
      nPass++;
    end else begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Main program: instruction stream with hand-computed results.
    addW(32'h3000, 32'h34011234, 0, 5'd1,  32'h00001234);  // ori $1,$0,0x1234
    addM(32'h3004, 32'hAC010004, 4'b1111, 32'h4, 32'h00001234); // sw $1,4($0)
    addM(32'h3008, 32'hA0010005, 4'b0010, 32'h5, 32'h34343434); // sb $1,5($0)
    addN(32'h300c, 32'h8C020003, 0);                       // lw misaligned -> AdEL
    addW(32'h4180, 32'h40037000, 0, 5'd3,  32'h0000300c);  // mfc0 $3,EPC
    addW(32'h4184, 32'h40036800, 0, 5'd3,  32'h00000010);  // mfc0 $3,Cause
    addW(32'h4188, 32'h40036000, 0, 5'd3,  32'h00000002);  // mfc0 $3,SR (EXL)
    addW(32'h418c, 32'h401A7000, 0, 5'd26, 32'h0000300c);  // mfc0 $k0,EPC
    addW(32'h4190, 32'h235A0004, 0, 5'd26, 32'h00003010);  // addi $k0,$k0,4
    addN(32'h4194, 32'h409A7000, 0);                       // mtc0 $k0,EPC
    addN(32'h4198, 32'h42000018, 0);                       // eret
    addW(32'h3010, 32'h40086000, 0, 5'd8,  32'h00000000);  // mfc0 $8,SR
    addW(32'h3014, 32'h8C020004, 0, 5'd2,  32'h00003434);  // lw $2,4($0)
    addW(32'h3018, 32'h80060005, 0, 5'd6,  32'h00000034);  // lb $6,5($0)
    addW(32'h301c, 32'h34045555, 0, 5'd4,  32'h00005555);  // ori $4
    addW(32'h3020, 32'h3C057FFF, 0, 5'd5,  32'h7fff0000);  // lui $5
    addW(32'h3024, 32'h34A5FFFF, 0, 5'd5,  32'h7fffffff);  // ori $5
    addN(32'h3028, 32'h20A40001, 0);                       // addi ov
    addW(32'h4180, 32'h40036800, 0, 5'd3,  32'h00000030);
    addW(32'h4184, 32'h40037000, 0, 5'd3,  32'h00003028);
    addW(32'h4188, 32'h401A7000, 0, 5'd26, 32'h00003028);
    addW(32'h418c, 32'h235A0004, 0, 5'd26, 32'h0000302c);
    addN(32'h4190, 32'h409A7000, 0);
    addN(32'h4194, 32'h42000018, 0);
    addW(32'h302c, 32'h00803825, 0, 5'd7,  32'h00005555);  // or $7,$4,$0 ($4 untouched)
    addW(32'h3030, 32'h00214020, 0, 5'd8,  32'h00002468);  // add
    addW(32'h3034, 32'h00244822, 0, 5'd9,  32'hFFFFBCDF);  // sub
    addW(32'h3038, 32'h0121502A, 0, 5'd10, 32'h00000001);  // slt
    addW(32'h303c, 32'h00A45824, 0, 5'd11, 32'h00005555);  // and
    addW(32'h3040, 32'h01256023, 0, 5'd12, 32'h7FFFBCE0);  // subu
    addW(32'h3044, 32'h00A56821, 0, 5'd13, 32'hFFFFFFFE);  // addu
    addM(32'h3048, 32'hA0090006, 4'b0100, 32'h6, 32'hDFDFDFDF); // sb $9,6($0)
    addW(32'h304c, 32'h800E0006, 0, 5'd14, 32'hFFFFFFDF);  // lb sign-extend
    addN(32'h3050, 32'h34000005, 0);                       // ori $0 -> no write
    addN(32'h3054, 32'h10210002, 0);                       // beq taken
    addN(32'h3060, 32'h14210002, 0);                       // bne not taken
    addW(32'h3064, 32'h0C000C20, 0, 5'd31, 32'h00003068);  // jal 0x3080
    addN(32'h3080, 32'h03E00008, 0);                       // jr $31
    addN(32'h3068, 32'h08000C24, 0);                       // j 0x3090
    addW(32'h3090, 32'h340F3002, 0, 5'd15, 32'h00003002);
    addN(32'h3094, 32'h01E00008, 0);                       // jr to misaligned PC
    addN(32'h3002, 32'h34011111, 0);                       // fetch AdEL
    addW(32'h4180, 32'h40036800, 0, 5'd3,  32'h00000010);
    addN(32'h4184, 32'h0000000C, 0);                       // syscall, EXL already set
    addW(32'h4180, 32'h40036800, 0, 5'd3,  32'h00000020);
    addW(32'h4184, 32'h40037000, 0, 5'd3,  32'h00003002);  // EPC kept
    addN(32'h4188, 32'hFC000000, 0);                       // RI
    addW(32'h4180, 32'h40036800, 0, 5'd3,  32'h00000028);
    addN(32'h4184, 32'hAC013000, 0);                       // sw out of range -> AdES
    addW(32'h4180, 32'h40036800, 0, 5'd3,  32'h00000014);
    addN(32'h4184, 32'h8006FFFF, 0);                       // lb out of range -> AdEL
    addW(32'h4180, 32'h40036800, 0, 5'd3,  32'h00000010);
    addW(32'h4184, 32'h34108401, 0, 5'd16, 32'h00008401);
    addN(32'h4188, 32'h40906000, 0);                       // mtc0 SR=8401
    addW(32'h418c, 32'h40116000, 0, 5'd17, 32'h00008401);
`ifdef INTERRUPT_EN
    addN(32'h4190, 32'h34120077, 1);                       // interrupt taken
    addW(32'h4180, 32'h40037000, 0, 5'd3,  32'h00004190);
    addW(32'h4184, 32'h40036800, 1, 5'd3,  32'h00008000);  // IP7 visible, EXL masks
`else
    addW(32'h4190, 32'h34120077, 1, 5'd18, 32'h00000077);  // interrupt ignored
    addW(32'h4194, 32'h40037000, 0, 5'd3,  32'h00003002);
    addW(32'h4198, 32'h40036800, 1, 5'd3,  32'h00000010);
`endif

    // Reset phase: outputs stay quiet even with a store/ALU op on the bus.
    reset = 1'b1;
    applyStimulus(32'hAC010004, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset pc", bus.macroscopic_pc, 32'h3000);
    checkOutput("reset byteen", {28'b0, bus.m_data_byteen}, 32'h0);
    applyStimulus(32'h34011234, 1'b0);
    #1;
    checkOutput("reset we", {31'b0, bus.w_grf_we}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Table-driven run
    for (int i = 0; i < nVec; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].instr, vecs[i].irq);
      #1;
      checkOutput($sformatf("v%0d pc", i), bus.macroscopic_pc, vecs[i].pc);
      checkOutput($sformatf("v%0d we", i), {31'b0, bus.w_grf_we}, {31'b0, vecs[i].we});
      checkOutput($sformatf("v%0d byteen", i), {28'b0, bus.m_data_byteen}, {28'b0, vecs[i].be});
      if (vecs[i].we) begin
        checkOutput($sformatf("v%0d waddr", i), {27'b0, bus.w_grf_addr}, {27'b0, vecs[i].wa});
        checkOutput($sformatf("v%0d wdata", i), bus.w_grf_wdata, vecs[i].wd);
        checkOutput($sformatf("v%0d winst", i), bus.w_inst_addr, vecs[i].pc);
      end
      if (vecs[i].be != 4'b0000) begin
        checkOutput($sformatf("v%0d maddr", i), bus.m_data_addr, vecs[i].ma);
        checkOutput($sformatf("v%0d mwdata", i), bus.m_data_wdata, vecs[i].md);
      end
    end

    // Mid-run reset: PC, GRF and CP0 must all return to their reset values.
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(32'h00201825, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rerun pc", bus.macroscopic_pc, 32'h3000);
    checkOutput("rerun we", {31'b0, bus.w_grf_we}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    applyStimulus(32'h00201825, 1'b0);                     // or $3,$1,$0
    #1;
    checkOutput("rerun or we", {31'b0, bus.w_grf_we}, 32'h1);
    checkOutput("rerun grf cleared", bus.w_grf_wdata, 32'h0);
    @(negedge clk);
    applyStimulus(32'h40036000, 1'b0);                     // mfc0 $3,SR
    #1;
    checkOutput("rerun pc2", bus.macroscopic_pc, 32'h3004);
    checkOutput("rerun sr", bus.w_grf_wdata, 32'h0);
    @(negedge clk);
    applyStimulus(32'h40037000, 1'b0);                     // mfc0 $3,EPC
    #1;
    checkOutput("rerun epc", bus.w_grf_wdata, 32'h0);

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
